// File: rtl/shiftreg_seq_ctrl.sv
// Parallel-in/serial-out sequencer: accepts a word over valid/ready and streams
// up to WIDTH bits onto a 1-bit link with back-pressure, abort and a done pulse.
module shiftreg_seq_ctrl #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [CNT_W-1:0] in_len,
    input  logic             in_dir,
    output logic             ser_out,
    output logic             ser_valid,
    input  logic             ser_ready,
    input  logic             abort,
    output logic             busy,
    output logic             done
);

    localparam logic [CNT_W-1:0] LEN_MAX = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state, state_d;
    logic [WIDTH-1:0] sreg, sreg_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic             dir, dir_d;

    logic in_ready_d, ser_valid_d, ser_out_d, busy_d, done_d;

    // State, datapath and registered outputs; outputs are decoded from next state
    // so they line up with the state they describe.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state     <= IDLE;
            sreg      <= '0;
            cnt       <= '0;
            dir       <= 1'b0;
            in_ready  <= 1'b0;
            ser_valid <= 1'b0;
            ser_out   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_d;
            sreg      <= sreg_d;
            cnt       <= cnt_d;
            dir       <= dir_d;
            in_ready  <= in_ready_d;
            ser_valid <= ser_valid_d;
            ser_out   <= ser_out_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

    // Next-state, shift/count update and output decode.
    always_comb begin
        state_d = state;
        sreg_d  = sreg;
        cnt_d   = cnt;
        dir_d   = dir;

        unique case (state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    sreg_d  = in_data;
                    dir_d   = in_dir;
                    cnt_d   = ((in_len == '0) || (in_len > LEN_MAX)) ? LEN_MAX : in_len;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // Abort wins over a beat presented in the same cycle.
                if (abort) begin
                    state_d = IDLE;
                    sreg_d  = '0;
                    cnt_d   = '0;
                end else if (ser_ready) begin
                    sreg_d = dir ? {1'b0, sreg[WIDTH-1:1]} : {sreg[WIDTH-2:0], 1'b0};
                    cnt_d  = cnt - CNT_ONE;
                    if (cnt == CNT_ONE) begin
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        in_ready_d  = (state_d == IDLE);
        ser_valid_d = (state_d == SHIFT);
        busy_d      = (state_d == SHIFT);
        done_d      = (state_d == DONE);
        ser_out_d   = (state_d == SHIFT) ? (dir_d ? sreg_d[0] : sreg_d[WIDTH-1]) : 1'b0;
    end

endmodule

// File: tb/tb_shiftreg_seq_ctrl.sv
// Self-checking bench for shiftreg_seq_ctrl: directed scenarios plus randomized
// frames compared against a bit-list model of the serial stream.
module tb_shiftreg_seq_ctrl;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned CNT_W = 4;

    logic             clk = 1'b0;
    logic             clear = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = '0;
    logic [CNT_W-1:0] in_len = '0;
    logic             in_dir = 1'b0;
    logic             ser_out;
    logic             ser_valid;
    logic             ser_ready = 1'b0;
    logic             abort = 1'b0;
    logic             busy;
    logic             done;

    int tests = 0;
    int fails = 0;

    logic [15:0] bits, exp_bits;
    int nb, nd, done_c, rdy_c, last_c, herr, wc, exp_len;

    shiftreg_seq_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_len(in_len), .in_dir(in_dir),
        .ser_out(ser_out), .ser_valid(ser_valid), .ser_ready(ser_ready),
        .abort(abort), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Reference: the bits a frame should put on the wire, in send order.
    function automatic void model(input logic [WIDTH-1:0] d, input logic [CNT_W-1:0] len,
                                  input logic dir, output logic [15:0] b, output int l);
        l = (len == 0 || int'(len) > WIDTH) ? WIDTH : int'(len);
        b = '0;
        for (int i = 0; i < l; i++) b[i] = dir ? d[i] : d[WIDTH-1-i];
    endfunction

    // Drives one frame from a negedge; returns at the negedge where in_ready is seen again.
    // mode: 0 = ser_ready always 1, 1 = random, 2 = pattern 1,0,0 repeating.
    task automatic send_frame(input logic [WIDTH-1:0] d, input logic [CNT_W-1:0] len,
                              input logic dir, input int mode, input int abort_at,
                              input logic keep, input logic [WIDTH-1:0] nxt);
        logic pv, pb, po, r, a;
        bits = '0; nb = 0; nd = 0; done_c = -1; rdy_c = -1; last_c = -1; herr = 0; wc = 0;
        in_data = d; in_len = len; in_dir = dir; in_valid = 1'b1;
        while (!in_ready && wc < 100) begin
            @(negedge clk);
            wc++;
        end
        if (!in_ready) begin
            tests++; fails++;
            $display("FAIL accept_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, wc);
            in_valid = 1'b0;
            return;
        end
        @(negedge clk);
        if (keep) in_data = nxt;
        else in_valid = 1'b0;
        pv = 1'b0; pb = 1'b0; po = 1'b0;
        for (int c = 1; c < 200; c++) begin
            if (in_ready) begin
                rdy_c = c;
                break;
            end
            if (done) begin
                nd++;
                done_c = c;
            end
            if (pv && ser_valid && !pb && ser_out !== po) herr++;
            case (mode)
                0:       r = 1'b1;
                1:       r = 1'($urandom_range(0, 1));
                default: r = (c % 3 == 1);
            endcase
            a = (abort_at >= 0) && ser_valid && (nb == abort_at);
            if (a) r = 1'b1;
            ser_ready = r;
            abort = a;
            pb = ser_valid && r && !a;
            if (pb) begin
                bits[nb] = ser_out;
                nb++;
                last_c = c;
            end
            pv = ser_valid;
            po = ser_out;
            @(negedge clk);
        end
        ser_ready = 1'b0;
        abort = 1'b0;
        if (rdy_c < 0) begin
            tests++; fails++;
            $display("FAIL frame_timeout: in_ready never returned, required within 200 cycles");
        end
    endtask

    task automatic test_reset();
        #1;
        tests++;
        if ({in_ready, ser_valid, ser_out, busy, done} !== 5'b0) begin
            fails++;
            $display("FAIL reset_outputs: got %05b, required 00000",
                     {in_ready, ser_valid, ser_out, busy, done});
        end
        @(negedge clk);
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        tests++;
        if ({in_ready, busy, ser_valid} !== 3'b100) begin
            fails++;
            $display("FAIL reset_release: in_ready/busy/ser_valid=%03b, required 100",
                     {in_ready, busy, ser_valid});
        end
    endtask

    task automatic test_msb_basic();
        send_frame(8'hA5, 4'd0, 1'b0, 0, -1, 1'b0, 8'h00);
        model(8'hA5, 4'd0, 1'b0, exp_bits, exp_len);
        tests++;
        if (bits !== exp_bits || nb != exp_len) begin
            fails++;
            $display("FAIL msb_bits: got %h/%0d beats, required %h/%0d", bits, nb, exp_bits, exp_len);
        end
        tests++;
        if (done_c != 9 || nd != 1 || rdy_c != 10 || last_c != 8) begin
            fails++;
            $display("FAIL msb_timing: last=%0d done=%0d(x%0d) ready=%0d, required 8 9(x1) 10",
                     last_c, done_c, nd, rdy_c);
        end
    endtask

    task automatic test_lsb_short();
        send_frame(8'hA5, 4'd3, 1'b1, 0, -1, 1'b0, 8'h00);
        tests++;
        if (bits !== 16'b101 || nb != 3 || done_c != 4 || nd != 1) begin
            fails++;
            $display("FAIL lsb_len3: got %b/%0d beats done@%0d, required 101/3 done@4",
                     bits[2:0], nb, done_c);
        end
        send_frame(8'h6C, 4'd12, 1'b1, 0, -1, 1'b0, 8'h00);
        model(8'h6C, 4'd12, 1'b1, exp_bits, exp_len);
        tests++;
        if (bits !== exp_bits || nb != 8 || done_c != 9) begin
            fails++;
            $display("FAIL lsb_len12_clamp: got %h/%0d done@%0d, required %h/8 done@9",
                     bits, nb, done_c, exp_bits);
        end
        send_frame(8'h80, 4'd1, 1'b0, 0, -1, 1'b0, 8'h00);
        tests++;
        if (bits !== 16'h0001 || nb != 1 || done_c != 2 || rdy_c != 3) begin
            fails++;
            $display("FAIL len1: got %h/%0d done@%0d ready@%0d, required 0001/1 done@2 ready@3",
                     bits, nb, done_c, rdy_c);
        end
    endtask

    task automatic test_backpressure();
        send_frame(8'hF0, 4'd0, 1'b0, 2, -1, 1'b0, 8'h00);
        tests++;
        if (bits !== 16'h000F || nb != 8 || herr != 0) begin
            fails++;
            $display("FAIL bp_bits: got %h/%0d beats, %0d hold errors, required 000f/8/0",
                     bits, nb, herr);
        end
        tests++;
        if (nd != 1 || done_c != last_c + 1) begin
            fails++;
            $display("FAIL bp_done: done x%0d @%0d, last beat @%0d, required x1 right after",
                     nd, done_c, last_c);
        end
    endtask

    task automatic test_abort();
        send_frame(8'hFF, 4'd0, 1'b0, 0, 3, 1'b0, 8'h00);
        tests++;
        if (nb != 3 || nd != 0 || rdy_c != 5) begin
            fails++;
            $display("FAIL abort: beats=%0d done x%0d ready@%0d, required 3 x0 @5", nb, nd, rdy_c);
        end
        send_frame(8'h81, 4'd0, 1'b0, 0, -1, 1'b0, 8'h00);
        tests++;
        if (bits !== 16'h0081 || nb != 8 || nd != 1) begin
            fails++;
            $display("FAIL after_abort: got %h/%0d done x%0d, required 0081/8 x1", bits, nb, nd);
        end
    endtask

    task automatic test_back_to_back();
        send_frame(8'h5A, 4'd0, 1'b0, 0, -1, 1'b1, 8'hC3);
        model(8'h5A, 4'd0, 1'b0, exp_bits, exp_len);
        tests++;
        if (bits !== exp_bits || rdy_c != 10) begin
            fails++;
            $display("FAIL b2b_first: got %h ready@%0d, required %h ready@10", bits, rdy_c, exp_bits);
        end
        send_frame(8'hC3, 4'd5, 1'b1, 0, -1, 1'b0, 8'h00);
        model(8'hC3, 4'd5, 1'b1, exp_bits, exp_len);
        tests++;
        if (wc != 0 || bits !== exp_bits || nb != exp_len) begin
            fails++;
            $display("FAIL b2b_second: wait=%0d got %h/%0d, required 0 %h/%0d",
                     wc, bits, nb, exp_bits, exp_len);
        end
    endtask

    task automatic test_reset_midframe();
        int dones;
        dones = 0;
        in_data = 8'hA5; in_len = 4'd0; in_dir = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        ser_ready = 1'b1;
        repeat (3) @(negedge clk);
        ser_ready = 1'b0;
        clear = 1'b0;
        #1;
        tests++;
        if ({in_ready, ser_valid, ser_out, busy, done} !== 5'b0) begin
            fails++;
            $display("FAIL midframe_reset: got %05b, required 00000",
                     {in_ready, ser_valid, ser_out, busy, done});
        end
        repeat (2) begin
            @(negedge clk);
            if (done) dones++;
        end
        clear = 1'b1;
        @(negedge clk);
        if (done) dones++;
        tests++;
        if (in_ready !== 1'b1 || dones != 0) begin
            fails++;
            $display("FAIL midframe_release: in_ready=%0b dones=%0d, required 1 0", in_ready, dones);
        end
        send_frame(8'h3C, 4'd0, 1'b0, 0, -1, 1'b0, 8'h00);
        tests++;
        if (bits !== 16'h003C || nb != 8 || wc != 0) begin
            fails++;
            $display("FAIL midframe_next: got %h/%0d wait=%0d, required 003c/8/0", bits, nb, wc);
        end
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] d;
        logic [CNT_W-1:0] len;
        logic dir;
        for (int i = 0; i < 40; i++) begin
            d   = WIDTH'($urandom);
            len = CNT_W'($urandom);
            dir = 1'($urandom);
            send_frame(d, len, dir, 1, -1, 1'b0, 8'h00);
            model(d, len, dir, exp_bits, exp_len);
            tests++;
            if (bits !== exp_bits || nb != exp_len || nd != 1 || herr != 0
                || done_c != last_c + 1 || rdy_c != done_c + 1) begin
                fails++;
                $display("FAIL rand_%0d d=%h len=%0d dir=%0b: got %h/%0d done x%0d@%0d last@%0d ready@%0d herr=%0d, required %h/%0d",
                         i, d, len, dir, bits, nb, nd, done_c, last_c, rdy_c, herr, exp_bits, exp_len);
            end
        end
    endtask

    initial begin
        test_reset();
        test_msb_basic();
        test_lsb_short();
        test_backpressure();
        test_abort();
        test_back_to_back();
        test_reset_midframe();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/shiftreg_seq_ctrl.md
Name: shiftreg_seq_ctrl

Overview:
Sequencer that owns a parallel-in/serial-out shift register and streams words onto a 1-bit serial link. A producer hands over a parallel word, a bit count and a direction through a valid/ready handshake. The block then shifts the word out one bit per accepted serial beat, honouring downstream back-pressure, and pulses done at the end of each frame. It sits between the parallel datapath and the serial shift-register chain.

Parameters:
WIDTH, 8, parallel word width in bits (2..16)
CNT_W, 4, bit-counter width; must satisfy 2**CNT_W > WIDTH

Ports:
clk  input  1  clock; all state updates on posedge
clear  input  1  asynchronous, active-low reset
in_valid  input  1  producer has a word
in_ready  output  1  controller can accept a word
in_data  input  WIDTH  parallel word to serialise
in_len  input  CNT_W  number of bits to send; 0 means WIDTH; values > WIDTH are clamped to WIDTH
in_dir  input  1  0 = MSB-first, 1 = LSB-first
ser_out  output  1  current serial bit
ser_valid  output  1  ser_out is valid
ser_ready  input  1  downstream accepts the bit this cycle
abort  input  1  synchronous frame cancel
busy  output  1  frame in progress
done  output  1  one-cycle pulse after the last bit is accepted

Behaviour:
- Reset: one clock; clear is asynchronous and active-low. While clear=0, state=IDLE, the shift register and counter are 0, and in_ready, ser_valid, ser_out, busy and done are all 0. This includes reset asserted mid-frame: the frame is dropped and no done is produced. After clear rises, in_ready=1 from the first cycle.
- States: IDLE, SHIFT, DONE. Outputs are decoded from state and registers. There is no combinational path from in_* to ser_*.
- IDLE: in_ready=1, busy=0, ser_valid=0.
  - Accept when in_valid && in_ready at a posedge.
  - On accept: capture in_data into the shift register, capture in_dir, and load the counter with the effective length L (0 or >WIDTH gives WIDTH).
  - Next state is SHIFT.
- SHIFT: in_ready=0, busy=1, ser_valid=1.
  - ser_out = sreg[WIDTH-1] when dir=0, sreg[0] when dir=1.
  - A beat occurs when ser_valid && ser_ready. On a beat the register shifts by one (left when dir=0, right when dir=1), vacated bits fill with 0, and the counter decrements.
  - With no beat, sreg, the counter and ser_out hold stable, so the stall can last indefinitely.
  - A beat with counter==1 moves to DONE.
- DONE: busy=0, ser_valid=0, in_ready=0, done=1 for exactly this cycle. Next state is IDLE unconditionally.
- Latency with ser_ready held at 1:
  - Accept at edge k.
  - Bits are valid in cycles k+1 .. k+L.
  - done in cycle k+L+1.
  - in_ready=1 in cycle k+L+2.
  - Minimum frame-to-frame period is L+2 cycles.
- Abort:
  - In SHIFT, abort=1 goes to IDLE at the next edge, with no done pulse and no beat counted. This holds even if ser_ready=1 in the same cycle, because abort has priority.
  - In IDLE or DONE, abort has no effect, so DONE still pulses.
- in_valid asserted during SHIFT or DONE is ignored. The producer must hold in_valid until it sees in_ready.
- L=1: single beat, then DONE.
- Untransmitted bits of a shorter-than-WIDTH frame are discarded. The bits sent are the top L (dir=0) or bottom L (dir=1) bits of in_data.

Test Plan:
- Reset mid-frame: WIDTH=8, send 8'hA5 with len=0, dir=0; pull clear low after 3 beats → all outputs 0 immediately, no done; after release in_ready=1 and the next frame 8'h3C streams 0,0,1,1,1,1,0,0.
- Basic MSB-first: in_data=8'hA5, len=0, dir=0, ser_ready=1 → ser_out 1,0,1,0,0,1,0,1 over cycles k+1..k+8; done at k+9; in_ready=1 at k+10.
- LSB-first, short length: in_data=8'hA5, len=3, dir=1 → ser_out 1,0,1; done 1 cycle after the third beat; len=12 behaves as len=8.
- Back-pressure: 8'hF0 MSB-first with ser_ready toggling 1,0,0,1,... → ser_out holds during stalls; exactly 8 beats 1,1,1,1,0,0,0,0; done only after the 8th beat.
- Abort: abort pulsed with ser_ready=1 during the 4th bit of 8'hFF → IDLE next cycle, no done, beat count 3; the following frame 8'h81 streams correctly.
- Handshake ordering: in_valid held high continuously with two words queued → second accepted exactly at the first cycle in_ready=1 after done; in_valid during SHIFT never alters in-flight data.
